pattern_detect_ctrl: RTL and testbench
======================================

// Module: pattern_detect_ctrl
// PURPOSE
//  Configures, arms and sequences a programmable serial pattern detector (Mealy-style, like our fixed 0110 FSMs).
//  Host loads pattern/length/overlap/target via valid-ready, pulses start; block scans serial bit stream x,
//  emits same-cycle match pulse y, counts matches, raises done at target count. Sits between host regs and a serial RX lane.
// PARAMETERS
//  MAXLEN  8   max pattern length in bits (>=2)
//  LENW    4   width of cfg_len; must hold MAXLEN
//  CNTW    8   width of match counter / target
// PORTS
//  clk          in   1       rising-edge clock (single clock domain)
//  reset        in   1       synchronous, active-high reset
//  cfg_valid    in   1       config beat valid
//  cfg_ready    out  1       config accepted when valid&ready; high only in IDLE
//  cfg_pattern  in   MAXLEN  pattern; bit [len-1] = first bit received, bit [0] = last
//  cfg_len      in   LENW    pattern length; legal 1..MAXLEN
//  cfg_overlap  in   1       1 = overlapping matches, 0 = history cleared after each match
//  cfg_target   in   CNTW    matches to reach done; 0 = free-run (never done)
//  start        in   1       arm pulse (IDLE or DONE)
//  abort        in   1       return to IDLE from any state
//  x            in   1       serial data bit
//  x_valid      in   1       x qualifier; bits shift only when high
//  y            out  1       combinational match pulse (Mealy: depends on x this cycle)
//  match_count  out  CNTW    registered match count, saturates at all-ones
//  busy         out  1       high in ARMED
//  done         out  1       high in DONE, held
//  cfg_err      out  1       one-cycle registered pulse: start with illegal cfg_len
// BEHAVIOUR
//  Reset: state IDLE, cfg regs 0 (len 0 = illegal), history/fill 0, match_count 0, busy/done/cfg_err 0, y 0, cfg_ready 1.
//  States: IDLE -> ARMED on start with latched len in 1..MAXLEN (else cfg_err next cycle, stay IDLE).
//   ARMED -> DONE on the match making count == target (target!=0). DONE -> ARMED on start. Any -> IDLE on abort.
//  Priority same cycle: reset > abort > start > cfg/match. cfg_valid ignored outside IDLE.
//  Arming (start accepted): history, fill and match_count cleared in that edge; first bit is next x_valid cycle.
//  ARMED, x_valid=1: win = {hist, x}; y = (fill >= len-1) && (win[len-1:0] == pattern[len-1:0]).
//   Edge: hist <= win[MAXLEN-1:0] shifted in; fill <= min(fill+1, MAXLEN).
//   On y: match_count +1 (saturating); if overlap=0, fill <= 0 (hist content don't-care).
//  y=0 whenever not ARMED or x_valid=0. Latency: y same cycle as last pattern bit; match_count/done update next edge.
//  DONE: x ignored, count frozen. abort keeps match_count readable in IDLE; cleared only by next start or reset.
//  Reset mid-operation: immediate return to reset values on next edge, config lost.
// STRUCTURE
//  Package pattern_detect_pkg: state enum {IDLE, ARMED, DONE}, default MAXLEN/LENW/CNTW constants.
//  One sub-module: pattern_match_core (hist shift reg, fill counter, masked compare -> y, clear/overlap input).
//  Top holds config regs, FSM, match counter, cfg_err pulse.
// TESTING
//  1. pattern 0110 len4 overlap1 target0, stream 0,1,1,0,1,1,0 -> y on bits 4 and 7, match_count=2, done=0.
//  2. same stream overlap0 -> y only on bit 4, match_count=1.
//  3. target=2 overlap1, stream 0110110 then 0110 -> done after bit 7, further bits give y=0, count stays 2; start re-arms, count=0.
//  4. cfg_len=0 then start -> cfg_err one cycle, busy=0, state IDLE; cfg_valid in ARMED -> cfg_ready=0, config unchanged.
//  5. x_valid low gaps inside 0110 (0,-,1,1,-,-,0) -> single match, idle cycles shift nothing.
//  6. abort+start same cycle mid-stream -> IDLE, count retained; reset mid-ARMED -> all outputs reset values next cycle.

Source files
------------

// File: rtl/pattern_detect_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package pattern_detect_pkg;

  localparam int MAXLEN_DEF = 8;  // max pattern length in bits
  localparam int LENW_DEF   = 4;  // width of the length field, holds MAXLEN
  localparam int CNTW_DEF   = 8;  // width of match counter / target

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A length is usable only if it selects at least one bit and fits the window.
  function automatic logic len_legal(input int unsigned len, input int unsigned maxlen);
    return (len >= 1) && (len <= maxlen);
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial matcher: history shift register, fill counter and masked compare driving y.
// Latency: y_o is combinational on x_i (Mealy); history/fill update on the next edge.
// Backpressure: none; en_i qualifies each bit, nothing shifts while it is low.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear_i      empties the history (arming)
//   en_i         accept x_i this cycle (ARMED and bit valid)
//   x_i          serial data bit
//   pattern_i    pattern, bit [len-1] is the first bit received
//   len_i        active pattern length, 1..MAXLEN
//   overlap_i    0 = history restarts after every match
//   y_o          match pulse
module pattern_match_core
  import pattern_detect_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int LENW   = LENW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              x_i,
  input  logic [MAXLEN-1:0] pattern_i,
  input  logic [LENW-1:0]   len_i,
  input  logic              overlap_i,
  output logic              y_o
);

  // Only MAXLEN-1 past bits are ever needed: the newest bit comes from x_i.
  logic [MAXLEN-2:0] hist_q, hist_d;
  logic [LENW-1:0]   fill_q, fill_d;
  logic [MAXLEN-1:0] win;
  logic [MAXLEN-1:0] mask;
  logic              filled;
  logic              hit;

  always_comb begin
    win = {hist_q, x_i};
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i < int'(len_i));
    end
    // fill counts valid history bits; len-1 of them plus x_i complete a window.
    filled = (fill_q >= (len_i - LENW'(1)));
    hit    = (((win ^ pattern_i) & mask) == '0);
    y_o    = en_i && filled && hit;
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (en_i) begin
      hist_d = win[MAXLEN-2:0];
      if (y_o && !overlap_i) begin
        // Stale history bits stay in hist but are masked out by fill.
        fill_d = '0;
      end else if (fill_q != LENW'(MAXLEN)) begin
        fill_d = fill_q + LENW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Configures, arms and sequences the serial pattern detector; counts matches to a target.
// Latency: y same cycle as the last pattern bit; match_count/done/busy/cfg_err one edge later.
// Backpressure: cfg_ready high only in IDLE (and not during a start/abort cycle).
//
// Ports:
//   clk, reset                         clock and synchronous active-high reset
//   cfg_valid/cfg_ready                config handshake; pattern/len/overlap/target
//   start, abort                       arm (from IDLE or DONE) / return to IDLE
//   x, x_valid                         serial bit and qualifier
//   y                                  combinational match pulse
//   match_count, busy, done, cfg_err   status
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int LENW   = LENW_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic              start,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
  output logic              y,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] pattern_q;
  logic [LENW-1:0]   len_q;
  logic              overlap_q;
  logic [CNTW-1:0]   target_q;
  logic [CNTW-1:0]   count_q, count_d, count_inc;
  logic              cfg_err_q, cfg_err_d;
  logic              arm;
  logic              match_en;
  logic              y_int;
  logic              len_ok;

  assign len_ok    = len_legal(32'(len_q), MAXLEN);
  // abort outranks a match, so the matcher is gated off in the abort cycle.
  assign match_en  = (state_q == ST_ARMED) && x_valid && !abort;
  assign count_inc = (count_q == '1) ? count_q : count_q + CNTW'(1);

  pattern_match_core #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (arm),
    .en_i      (match_en),
    .x_i       (x),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .y_o       (y_int)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    arm       = 1'b0;
    cfg_err_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_d = ST_ARMED;
              arm     = 1'b1;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          // Target 0 means free-run: never leave ARMED on a match.
          if (y_int && (target_q != '0) && (count_inc == target_q)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_ARMED;
            arm     = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q == ST_ARMED);
    done      = (state_q == ST_DONE);
    // Withheld while start/abort is asserted so a completed handshake is
    // never silently dropped by a higher-priority event.
    cfg_ready = (state_q == ST_IDLE) && !start && !abort;
    y         = y_int;
  end

  always_comb begin
    count_d = count_q;
    if (arm) begin
      count_d = '0;
    end else if (y_int) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        target_q  <= cfg_target;
      end
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: directed scenarios plus random traffic against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 2 time units after it.
// The model keeps the received bits as a queue and matches by direct comparison.
module tb_pattern_detect_ctrl;

  localparam int MAXLEN = 8;
  localparam int LENW   = 4;
  localparam int CNTW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              abort;
  logic              x;
  logic              x_valid;
  logic              y;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;
  logic              cfg_err;

  always #5 clk = ~clk;

  pattern_detect_ctrl #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW),
    .CNTW   (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .y           (y),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int y_pulses = 0;

  // Reference model state: 0 = idle, 1 = armed, 2 = done.
  int         m_state = 0;
  int         m_cnt   = 0;
  bit         m_err   = 1'b0;
  logic [7:0] m_pat   = '0;
  int         m_len   = 0;
  bit         m_ov    = 1'b0;
  int         m_tgt   = 0;
  bit         m_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_y();
    int n;
    bit b;
    if (m_state != 1 || x_valid !== 1'b1 || abort === 1'b1) return 1'b0;
    n = m_bits.size() + 1;
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == m_len - 1) ? bit'(x) : m_bits[n - m_len + k];
      if (b != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_arm();
    m_state = 1;
    m_cnt   = 0;
    m_bits.delete();
  endtask

  // One clock: check outputs against the model, advance the model, clear pulses.
  task automatic tick();
    bit ey;
    bit exp_rdy;
    #2;
    ey      = model_y();
    exp_rdy = (m_state == 0) && !start && !abort;
    check("y", y, ey);
    check("match_count", match_count, m_cnt);
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("cfg_err", cfg_err, m_err);
    check("cfg_ready", cfg_ready, exp_rdy);
    if (y === 1'b1) y_pulses++;

    if (reset) begin
      m_state = 0; m_cnt = 0; m_err = 1'b0;
      m_pat = '0; m_len = 0; m_ov = 1'b0; m_tgt = 0;
      m_bits.delete();
    end else begin
      m_err = 1'b0;
      if (abort) begin
        m_state = 0;
      end else if (start && m_state == 0) begin
        if (m_len >= 1 && m_len <= MAXLEN) model_arm();
        else m_err = 1'b1;
      end else if (start && m_state == 2) begin
        model_arm();
      end else if (m_state == 1 && x_valid) begin
        m_bits.push_back(x);
        if (m_bits.size() > 16) void'(m_bits.pop_front());
        if (ey) begin
          if (m_cnt < 255) m_cnt++;
          if (!m_ov) m_bits.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
        end
      end
      if (cfg_valid && exp_rdy) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len);
        m_ov = cfg_overlap; m_tgt = int'(cfg_target);
      end
    end

    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic send(input bit b);
    x = b; x_valid = 1'b1;
    tick();
  endtask

  // '0'/'1' send a bit, '-' is a cycle with x_valid low.
  task automatic send_str(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "-") tick();
      else send(c == "1");
    end
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ov, input logic [7:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
    cfg_valid = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
  endtask

  initial begin
    int r;
    int v;
    reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_y", y, 0);
    check("rst_cnt", match_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);

    // 1: overlapping 0110
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    do_start();
    y_pulses = 0;
    send_str("0110110");
    check("t1_pulses", y_pulses, 2);
    check("t1_cnt", match_count, 2);
    check("t1_done", done, 0);

    // 2: non-overlapping
    do_abort();
    do_cfg(8'h06, 4'd4, 1'b0, 8'd0);
    do_start();
    y_pulses = 0;
    send_str("0110110");
    check("t2_pulses", y_pulses, 1);
    check("t2_cnt", match_count, 1);

    // 3: target reached, DONE ignores bits, re-arm clears count
    do_abort();
    do_cfg(8'h06, 4'd4, 1'b1, 8'd2);
    do_start();
    send_str("0110110");
    check("t3_done", done, 1);
    check("t3_cnt", match_count, 2);
    y_pulses = 0;
    send_str("0110");
    check("t3_no_y", y_pulses, 0);
    check("t3_frozen", match_count, 2);
    do_start();
    check("t3_rearm_cnt", match_count, 0);
    check("t3_rearm_busy", busy, 1);

    // 4: illegal length, then config ignored while armed
    do_abort();
    do_cfg(8'h06, 4'd0, 1'b1, 8'd0);
    do_start();
    check("t4_err", cfg_err, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_err_pulse", cfg_err, 0);
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    do_start();
    cfg_pattern = 8'hFF; cfg_len = 4'd2; cfg_valid = 1'b1;
    #1;
    check("t4_rdy_armed", cfg_ready, 0);
    tick();
    y_pulses = 0;
    send_str("0110");
    check("t4_cfg_kept", y_pulses, 1);

    // 5: x_valid gaps
    do_abort();
    do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
    do_start();
    y_pulses = 0;
    send_str("0-11--0");
    check("t5_pulses", y_pulses, 1);
    check("t5_cnt", match_count, 1);

    // 6: abort beats start; reset mid-ARMED
    send_str("011");
    abort = 1'b1; start = 1'b1;
    tick();
    check("t6_idle", busy, 0);
    check("t6_cnt_kept", match_count, 1);
    do_start();
    send_str("0110");
    reset = 1'b1;
    tick();
    check("t6_rst_cnt", match_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rdy", cfg_ready, 1);
    do_start();
    check("t6_cfg_lost", cfg_err, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
      end else if (r < 4) begin
        abort = 1'b1;
      end else begin
        if (r < 8) start = 1'b1;
        if (r >= 8 && r < 14) begin
          cfg_valid   = 1'b1;
          cfg_pattern = 8'($urandom);
          v           = $urandom_range(0, 11);
          cfg_len     = (v < 9) ? 4'(v) : 4'($urandom_range(9, 15));
          cfg_overlap = 1'($urandom);
          cfg_target  = 8'($urandom_range(0, 6));
        end
        x_valid = ($urandom_range(0, 3) != 0);
        x       = 1'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
